alu_issue_stage: RTL
====================

# alu_issue_stage

ID/EX boundary stage that feeds the pipeline's combinational ALU. Decodes ALUOp/funct3/funct7 into the 4-bit ALU operation code, registers the operands, immediate and destination register across a valid/ready pipeline register, and drives SrcA/SrcB/Operation in EX. When enabled, it forwards results from EX/MEM and MEM/WB. Sits between the decode stage and the ALU; the ALU result leaves through the EX/MEM register, which this block does not own.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_W, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous reset, active-low
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  block can accept this cycle
- id_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  in  3  instruction funct3
- id_funct7  in  7  instruction funct7 (I-type: imm[11:5])
- id_alu_src  in  1  1: SrcB = immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  source/dest indices
- id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH each  register-file reads, sign-extended immediate
- flush  in  1  kill instruction held in EX
- ex_ready  in  1  EX/MEM can take the EX instruction
- ex_valid  out  1  EX holds a live instruction
- ex_illegal  out  1  decoded funct combination unsupported
- ex_rd  out  REG_ADDR_W  registered destination
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- exmem_regwrite, memwb_regwrite  in  1  producer writes rd
- exmem_rd, memwb_rd  in  REG_ADDR_W  producer destinations
- exmem_result, memwb_result  in  DATA_WIDTH  producer values

## Operation
- Op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, SLT 1100.
- alu_op 00: ADD.
- alu_op 01: funct3 000/001 → EQ; 100/101 → SLT; other → illegal.
- alu_op 10: funct3 000 → ADD, or SUB if funct7[5]; 001 SLL; 010 SLT; 100 XOR; 101 → SRL, or SRA if funct7[5]; 110 OR; 111 AND; 011 → illegal.
- alu_op 11: same as 10, except 000 is always ADD. funct7[5] still selects SRA.
- Illegal: Operation = 0000 and ex_illegal = 1 while valid. The flag is informational and does not stall.
- Decode is done in ID and the result is registered with the rest of the instruction.
- Register load: when id_valid && id_ready && !flush, capture all id_* fields; ex_valid ← 1.
- Otherwise, if ex_ready, ex_valid ← 0. If stalled (!ex_ready), hold every field.
- id_ready = !ex_valid || ex_ready (combinational; independent of flush).
- flush: ex_valid ← 0 next edge. It takes priority over a simultaneous load, and the incoming instruction is dropped.
- Operand A: forwarded rs1 value.
- Operand B: id_alu_src ? imm : forwarded rs2 value.
- Forward priority, per operand: EX/MEM match, then MEM/WB match, then registered rf data.
- Match = regwrite && rd ≠ 0 && rd == rs. Index 0 is never forwarded.
- When ex_valid = 0, SrcA/SrcB/Operation still reflect held register contents; consumers qualify with ex_valid.

## Timing
- Reset (reset_n low at edge): ex_valid 0, ex_illegal 0, ex_rd 0, all operand/immediate regs 0, decoded op 0000. SrcA/SrcB = 0 unless forwarding matches index 0 (never). Operation 0000. id_ready 1 after reset.
- Latency: instruction accepted at edge N appears on SrcA/SrcB/Operation from edge N up to N+1.
- Forwarding path is combinational in EX: producer inputs sampled in the same cycle.
- Back-to-back issue at full throughput when ex_ready stays 1.
- Reset mid-stall discards the held instruction.

## Configuration
- ALU_ISSUE_FWD_EN defined: forwarding muxes as above.
- Undefined: SrcA = registered rs1 data. SrcB = imm or registered rs2 data. Forwarding ports remain but are ignored.

## Structure
- alu_pkg: enum alu_op_e (ten codes above), typedef alu_ctrl_e for the 2-bit class, constant OP_W = 4.
- Sub-module alu_decoder: combinational alu_op/funct3/funct7 → {alu_op_e, illegal}.

## Test plan
- R-type funct3 000 funct7 0100000, rs1 data 10, rs2 data 3 → next cycle Operation 0110, SrcA 10, SrcB 3, ex_valid 1.
- I-type funct3 101 funct7 0100000, alu_src 1, imm 4 → Operation 0111, SrcB 4. I-type funct3 000 funct7 0100000 → ADD, not SUB.
- Forwarding: rs1 = 5, exmem_rd 5 result 0xAA, memwb_rd 5 result 0xBB → SrcA 0xAA. With rd = 0 and regwrite 1 → SrcA = register data.
- Stall: ex_ready 0 for 3 cycles with id_valid 1 → id_ready 0 and EX fields unchanged. Release → new instruction loads at the next edge.
- flush together with id_valid && id_ready → ex_valid 0 next cycle. A branch funct3 010 → ex_illegal 1, Operation 0000.
- reset_n low while stalled and valid → ex_valid 0, SrcA/SrcB 0, Operation 0000, id_ready 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, ALUOp class encoding and operation-code width.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        CTRL_MEM    = 2'b00,
        CTRL_BRANCH = 2'b01,
        CTRL_RTYPE  = 2'b10,
        CTRL_ITYPE  = 2'b11
    } alu_ctrl_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of ALUOp/funct3/funct7 into an ALU operation code plus an illegal flag.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    output logic [OP_W-1:0] op_o,
    output logic            illegal_o
);

    alu_ctrl_e ctrl;
    alu_op_e   op;
    logic      illegal;
    logic      alt;
    logic      unused_funct7;

    assign ctrl          = alu_ctrl_e'(alu_op_i);
    assign alt           = funct7_i[5];
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        unique case (ctrl)
            CTRL_MEM: op = OP_ADD;
            CTRL_BRANCH: begin
                case (funct3_i)
                    3'b000, 3'b001: op = OP_EQ;
                    3'b100, 3'b101: op = OP_SLT;
                    default:        illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct3_i)
                    // SUB only exists for register-register; I-type funct7 bits are immediate
                    3'b000:  op = (ctrl == CTRL_RTYPE && alt) ? OP_SUB : OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = alt ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    3'b111:  op = OP_AND;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
        if (illegal) begin
            op = OP_AND;
        end
    end

    assign op_o      = op;
    assign illegal_o = illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: decode, valid/ready handshake, optional operand forwarding.
// Forwarding from EX/MEM and MEM/WB is compiled in when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [1:0]               id_alu_op,
    input  logic [2:0]               id_funct3,
    input  logic [6:0]               id_funct7,
    input  logic                     id_alu_src,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     flush,
    input  logic                     ex_ready,
    output logic                     ex_valid,
    output logic                     ex_illegal,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     exmem_regwrite,
    input  logic                     memwb_regwrite,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [DATA_WIDTH-1:0]    memwb_result
);

    logic [OP_W-1:0]       dec_op;
    logic                  dec_illegal;
    logic                  load;
    logic                  valid_d, valid_q;
    logic                  illegal_q;
    logic                  alu_src_q;
    alu_op_e               op_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

    alu_decoder u_dec (
        .alu_op_i  (id_alu_op),
        .funct3_i  (id_funct3),
        .funct7_i  (id_funct7),
        .op_o      (dec_op),
        .illegal_o (dec_illegal)
    );

    assign id_ready = !valid_q || ex_ready;
    assign load     = id_valid && id_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (flush || ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            alu_src_q  <= 1'b0;
            op_q       <= OP_AND;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                illegal_q  <= dec_illegal;
                alu_src_q  <= id_alu_src;
                op_q       <= alu_op_e'(dec_op);
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
            end
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic fwd_hit(input logic wr, input logic [REG_ADDR_W-1:0] prod,
                                     input logic [REG_ADDR_W-1:0] rs);
        return wr && (prod != '0) && (prod == rs);
    endfunction

    // MEM/WB applied first so a younger EX/MEM hit overrides it
    always_comb begin
        fwd_a = rs1_data_q;
        fwd_b = rs2_data_q;
        if (fwd_hit(memwb_regwrite, memwb_rd, rs1_q)) fwd_a = memwb_result;
        if (fwd_hit(exmem_regwrite, exmem_rd, rs1_q)) fwd_a = exmem_result;
        if (fwd_hit(memwb_regwrite, memwb_rd, rs2_q)) fwd_b = memwb_result;
        if (fwd_hit(exmem_regwrite, exmem_rd, rs2_q)) fwd_b = exmem_result;
    end
`else
    logic unused_fwd;

    assign fwd_a      = rs1_data_q;
    assign fwd_b      = rs2_data_q;
    assign unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                          exmem_result, memwb_result, rs1_q, rs2_q};
`endif

    assign ex_valid   = valid_q;
    assign ex_illegal = valid_q && illegal_q;
    assign ex_rd      = rd_q;
    assign SrcA       = fwd_a;
    assign SrcB       = alu_src_q ? imm_q : fwd_b;
    assign Operation  = OPCODE_LENGTH'(op_q);

endmodule
